// File: rtl/mw_mem_ctrl.sv
// mw_mem_ctrl: memory/writeback controller; decodes in_* ops, drives dcache_* request/response handshake, emits registered wb_* bundle, stall and misalign
module mw_mem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [6:0]              in_opcode,
  input  logic [2:0]              in_funct3,
  input  logic [4:0]              in_rd,
  input  logic [DATA_WIDTH-1:0]   in_alu,
  input  logic [DATA_WIDTH-1:0]   in_store_data,
  input  logic [DATA_WIDTH-1:0]   in_pc4,
  output logic                    stall,
  output logic                    dcache_req_valid,
  input  logic                    dcache_req_ready,
  output logic [ADDR_WIDTH-1:0]   dcache_addr,
  output logic [DATA_WIDTH/8-1:0] dcache_we,
  output logic [DATA_WIDTH-1:0]   dcache_din,
  input  logic                    dcache_resp_valid,
  input  logic [DATA_WIDTH-1:0]   dcache_dout,
  output logic                    wb_valid,
  output logic                    wb_rwe,
  output logic [1:0]              wb_sel,
  output logic [4:0]              wb_rd,
  output logic [DATA_WIDTH-1:0]   wb_data,
  output logic                    misalign
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BYTES);
  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BYTES-1:0] we_q, we_d, mask;
  logic [DATA_WIDTH-1:0] din_q, din_d, rep, lane, lsh, ld_val, wb_data_q, wb_data_d;
  logic [OFFW-1:0] off_q, off_d, off;
  logic [2:0] f3_q, f3_d;
  logic [1:0] wb_sel_q, wb_sel_d, sz, sel;
  logic [4:0] wb_rd_q, wb_rd_d;
  logic [6:0] sh;
  logic ld_q, ld_d, wb_valid_q, wb_valid_d, wb_rwe_q, wb_rwe_d, misalign_q, misalign_d;
  logic is_load, is_store, mis;
  always_comb begin
    is_load = in_opcode == OP_LOAD;
    is_store = in_opcode == OP_STORE;
    sz = in_funct3[1:0];
    off = in_alu[OFFW-1:0];
    sel = is_load ? 2'd1 : (in_opcode == OP_JAL || in_opcode == OP_JALR) ? 2'd2 : 2'd0;
    mis = (DATA_WIDTH == 32 && (sz == 2'd3 || in_funct3 == 3'b110)) || (sz == 2'd1 && off[0]) ||
          (sz == 2'd2 && off[1:0] != 2'd0) || (sz == 2'd3 && off != '0);
    mask = sz == 2'd0 ? BYTES'(1) : sz == 2'd1 ? BYTES'(3) : sz == 2'd2 ? BYTES'(15) : '1;
    rep = sz == 2'd0 ? {BYTES{in_store_data[7:0]}} : sz == 2'd1 ? {(BYTES/2){in_store_data[15:0]}} :
          sz == 2'd2 ? {(DATA_WIDTH/32){in_store_data[31:0]}} : in_store_data;
    // Move the addressed lane to bit 0, push its top bit to the MSB, then shift back to extend
    lane = dcache_dout >> {off_q, 3'b000};
    sh = 7'(DATA_WIDTH) - (7'd8 << f3_q[1:0]);
    lsh = lane << sh;
    ld_val = f3_q[2] ? lsh >> sh : DATA_WIDTH'($signed(lsh) >>> sh);
    state_d = state_q;
    addr_d = addr_q;
    we_d = we_q;
    din_d = din_q;
    off_d = off_q;
    f3_d = f3_q;
    ld_d = ld_q;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;
    wb_rwe_d = wb_rwe_q;
    wb_sel_d = wb_sel_q;
    wb_rd_d = wb_rd_q;
    wb_data_d = wb_data_q;
    if (state_q == IDLE && in_valid) begin
      wb_rd_d = in_rd;
      wb_sel_d = sel;
      if (!(is_load || is_store)) begin
        wb_valid_d = 1'b1;
        wb_rwe_d = !(in_opcode == OP_BRANCH);
        wb_data_d = sel == 2'd2 ? in_pc4 : in_alu;
      end else if (mis) begin
        wb_valid_d = 1'b1;
        misalign_d = 1'b1;
        wb_rwe_d = 1'b0;
        wb_data_d = '0;
      end else begin
        state_d = REQ;
        addr_d = {in_alu[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
        we_d = is_store ? mask << off : '0;
        din_d = rep;
        off_d = off;
        f3_d = in_funct3;
        ld_d = is_load;
      end
    end else if (state_q == REQ && dcache_req_ready) begin
      state_d = ld_q ? RESP : IDLE;
      wb_valid_d = !ld_q;
      wb_rwe_d = 1'b0;
      wb_data_d = ld_q ? wb_data_q : '0;
    end else if (state_q == RESP && dcache_resp_valid) begin
      state_d = IDLE;
      wb_valid_d = 1'b1;
      wb_rwe_d = 1'b1;
      wb_data_d = ld_val;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q <= '0;
      we_q <= '0;
      din_q <= '0;
      off_q <= '0;
      f3_q <= '0;
      ld_q <= 1'b0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      wb_rwe_q <= 1'b0;
      wb_sel_q <= '0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      we_q <= we_d;
      din_q <= din_d;
      off_q <= off_d;
      f3_q <= f3_d;
      ld_q <= ld_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
      wb_rwe_q <= wb_rwe_d;
      wb_sel_q <= wb_sel_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end
  assign stall = state_q != IDLE;
  assign dcache_req_valid = state_q == REQ;
  assign dcache_addr = addr_q;
  assign dcache_we = we_q;
  assign dcache_din = din_q;
  assign wb_valid = wb_valid_q;
  assign wb_rwe = wb_rwe_q;
  assign wb_sel = wb_sel_q;
  assign wb_rd = wb_rd_q;
  assign wb_data = wb_data_q;
  assign misalign = misalign_q;
endmodule

// File: doc/mw_mem_ctrl.md
Name: mw_mem_ctrl

Overview:
Parametrised memory/writeback stage controller for the stage-3 pipeline. It is the successor to the purely combinational memory/writeback decode. Decodes opcode/funct3, generates byte-lane write masks and lane-shifted store data for DATA_WIDTH 32 or 64, and runs a valid/ready request plus response handshake to the data cache. Aligns and sign/zero-extends load data, stalls upstream while a memory op is outstanding, and emits a registered writeback bundle (data, rd, rwe, wb_sel).

Parameters:
DATA_WIDTH, 32, data bus width; legal values 32 or 64; BYTES = DATA_WIDTH/8.
ADDR_WIDTH, 32, byte address width.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
in_valid  in  1  instruction present from previous stage
in_opcode  in  7  RV opcode
in_funct3  in  3  RV funct3
in_rd  in  5  destination register
in_alu  in  DATA_WIDTH  ALU result; also the effective byte address for loads/stores (low ADDR_WIDTH bits)
in_store_data  in  DATA_WIDTH  rs2 value for stores
in_pc4  in  DATA_WIDTH  PC+4 for JAL/JALR
stall  out  1  upstream must hold its inputs
dcache_req_valid  out  1  request valid
dcache_req_ready  in  1  cache accepts request
dcache_addr  out  ADDR_WIDTH  word-aligned address (low log2(BYTES) bits zero)
dcache_we  out  BYTES  byte write mask; all zero means read
dcache_din  out  DATA_WIDTH  lane-shifted store data
dcache_resp_valid  in  1  load data valid
dcache_dout  in  DATA_WIDTH  load data word
wb_valid  out  1  writeback bundle valid, one-cycle pulse
wb_rwe  out  1  register write enable
wb_sel  out  2  0 = ALU, 1 = MEM, 2 = PC+4
wb_rd  out  5  destination register
wb_data  out  DATA_WIDTH  selected writeback data
misalign  out  1  one-cycle pulse on misaligned access

Behaviour:
- Reset (synchronous): state IDLE; wb_valid, wb_rwe, wb_sel, wb_rd, wb_data, misalign, dcache_req_valid all 0. Any in-flight request or response is dropped. A dcache_resp_valid arriving after reset is ignored.
- stall = (state != IDLE), combinational. An instruction is accepted when in_valid && !stall.
- Decode:
  - LOAD 0000011: wb_sel = 1, rwe = 1.
  - STORE 0100011: rwe = 0.
  - BRANCH 1100011: rwe = 0.
  - JAL 1101111 / JALR 1100111: wb_sel = 2, rwe = 1.
  - All others: wb_sel = 0, rwe = 1.
- Non-memory op accepted in cycle T: bundle registered, wb_valid = 1 in T+1, state stays IDLE.
- Alignment (off = addr[log2(BYTES)-1:0]):
  - Byte: any offset.
  - Half: off[0] = 0.
  - Word: off[1:0] = 0.
  - Double: off = 0, only when DATA_WIDTH = 64.
  - Misaligned access, or funct3 = 011/110 when DATA_WIDTH = 32: no cache request; wb_valid and misalign = 1 in T+1 with rwe = 0.
- Memory op accepted in cycle T: address, mask, data, kind and rd are captured; state goes to REQ.
- REQ state:
  - dcache_req_valid = 1.
  - addr/we/din held stable until dcache_req_ready.
  - On handshake, a store goes to IDLE with wb_valid (rwe = 0) the next cycle.
  - On handshake, a load goes to RESP.
- RESP state: dcache_resp_valid is sampled only here. On resp: the lane at off is extracted and sign- or zero-extended; wb_data is registered; wb_valid is 1 the next cycle; state goes to IDLE.
- Minimum latencies from accept T:
  - Non-memory: T+1.
  - Store: T+2.
  - Load: T+3, with zero-wait ready/resp.
- Store mask/data:
  - SB: we = 1 << off; byte replicated across all lanes.
  - SH: we = 2'b11 << off; half replicated.
  - SW: we = 4'hF << off; word replicated (64-bit only).
  - SD: we = all ones.
- Load funct3 for extension:
  - 000 LB, 001 LH, 010 LW and 011 LD: sign-extend.
  - 100 LBU, 101 LHU, 110 LWU (64-bit only): zero-extend.
  - For DATA_WIDTH = 32, LW is the full word.
- wb_valid, misalign and dcache_req_valid are never asserted in the same cycle as reset.

Test Plan:
1. DW = 32: SB addr 0x1003, data 0xAB, ready = 1 at T+1 -> dcache_addr 0x1000, we 4'b1000, din 0xABABABAB, wb_valid at T+2, rwe 0, stall high only at T+1.
2. LH addr 0x2002, ready low for 3 cycles, resp data 0x80011234 -> req fields stable all 3 cycles, wb_data 0xFFFF8001, wb_sel 1, rwe 1, stall high until resp cycle.
3. LBU addr 0x2001, resp 0x0000F000 -> wb_data 0x000000F0; LB same -> 0xFFFFFFF0.
4. SW addr 0x3002 -> no dcache_req_valid, misalign and wb_valid at T+1, rwe 0; next instruction accepted at T+1.
5. JAL rd 1, pc4 0x104 -> wb_valid at T+1, wb_sel 2, wb_data 0x104, rwe 1. BEQ -> rwe 0. DW = 64: SD addr 0x8 -> we 8'hFF, addr 0x8.
6. Reset asserted in RESP, resp_valid arrives next cycle -> stall 0, no wb_valid, all outputs 0.
